// File: rtl/updown_counter_n.sv
// Parametrised up/down counter with modulo limit, step, parallel load,
// wrap/saturate boundary handling, terminal-count pulse and sticky overflow.
module updown_counter_n #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] Q,
  output logic             at_max,
  output logic             at_min,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   q_w;
  logic [WIDTH:0]   s_w;
  logic [WIDTH:0]   lim_w;
  logic [WIDTH:0]   span_w;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   q_nxt;
  logic             evt;

  assign s      = (step < limit) ? step : limit;
  assign q_w    = {1'b0, Q};
  assign s_w    = {1'b0, s};
  assign lim_w  = {1'b0, limit};
  assign span_w = lim_w + {{WIDTH{1'b0}}, 1'b1};
  assign sum_w  = q_w + s_w;

  always_comb begin
    q_nxt = q_w;
    evt   = 1'b0;
    if (load) begin
      q_nxt = (load_val < limit) ? {1'b0, load_val} : lim_w;
    end else if (en && (s != '0)) begin
      // An out-of-range Q snaps to the far end of travel regardless of mode.
      if (q_w > lim_w) begin
        evt   = 1'b1;
        q_nxt = dir ? lim_w : '0;
      end else if (!dir) begin
        if (sum_w <= lim_w) begin
          q_nxt = sum_w;
        end else begin
          evt   = 1'b1;
          q_nxt = mode ? lim_w : (sum_w - span_w);
        end
      end else begin
        if (q_w >= s_w) begin
          q_nxt = q_w - s_w;
        end else begin
          evt   = 1'b1;
          q_nxt = mode ? '0 : (q_w + span_w - s_w);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      Q   <= WIDTH'(RESET_VAL);
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      Q   <= q_nxt[WIDTH-1:0];
      tc  <= evt;
      ovf <= evt | (ovf & ~clr_ovf);
    end
  end

  assign at_max = (Q == limit);
  assign at_min = (Q == '0);

endmodule

// File: tb/tb_updown_counter_n.sv
// Directed self-checking bench for updown_counter_n (WIDTH=4, RESET_VAL=0).
module tb_updown_counter_n;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset, en, dir, mode, load, clr_ovf;
  logic [W-1:0] step, limit, load_val;
  logic [W-1:0] Q;
  logic         at_max, at_min, tc, ovf;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  updown_counter_n #(.WIDTH(W), .RESET_VAL(0)) dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode),
    .step(step), .limit(limit), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .Q(Q), .at_max(at_max), .at_min(at_min),
    .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int q, input int t, input int o);
    check({tag, ".Q"},   32'(Q),   32'(q));
    check({tag, ".tc"},  32'(tc),  32'(t));
    check({tag, ".ovf"}, 32'(ovf), 32'(o));
  endtask

  int exp_q2  [7] = '{3, 6, 9, 2, 5, 8, 1};
  int exp_tc2 [7] = '{0, 0, 0, 1, 0, 0, 1};
  int exp_q3  [4] = '{1, 0, 0, 0};
  int exp_tc3 [4] = '{0, 1, 1, 1};
  int exp_min3[4] = '{0, 1, 1, 1};

  initial begin
    reset = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; clr_ovf = 1'b0;
    step = 4'd1; limit = 4'd15; load_val = '0;

    // reset and basic up count
    cyc(); cyc();
    chk_state("rst", 0, 0, 0);
    check("rst.at_min", 32'(at_min), 1);
    check("rst.at_max", 32'(at_max), 0);
    reset = 1'b1; en = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      cyc();
      chk_state($sformatf("up%0d", i), i % 16, (i == 16) ? 1 : 0, (i >= 16) ? 1 : 0);
    end

    // modulo limit with step 3, wrapping
    load = 1'b1; load_val = 4'd0; cyc();
    load = 1'b0;
    chk_state("ld0", 0, 0, 1);
    limit = 4'd9; step = 4'd3;
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk_state($sformatf("mod%0d", i), exp_q2[i], exp_tc2[i], 1);
      if (i == 2) check("mod.at_max", 32'(at_max), 1);
    end

    // down count with saturation
    load = 1'b1; load_val = 4'd4; cyc();
    load = 1'b0;
    check("ld4.Q", 32'(Q), 4);
    dir = 1'b1; mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk_state($sformatf("sat%0d", i), exp_q3[i], exp_tc3[i], 1);
      check($sformatf("sat%0d.at_min", i), 32'(at_min), 32'(exp_min3[i]));
    end

    // load clamps to limit and outranks en
    limit = 4'd7; load = 1'b1; load_val = 4'd12; dir = 1'b0; cyc();
    load = 1'b0;
    chk_state("clamp", 7, 0, 1);
    check("clamp.at_max", 32'(at_max), 1);
    limit = 4'd5; #1;
    check("oor.at_max", 32'(at_max), 0);
    cyc();
    chk_state("oor_up", 0, 1, 1);

    // sticky overflow clear, and set beating clear
    en = 1'b0; clr_ovf = 1'b1; cyc();
    clr_ovf = 1'b0;
    chk_state("clr", 0, 0, 0);
    mode = 1'b0; step = 4'd1; load = 1'b1; load_val = 4'd5; cyc();
    load = 1'b0;
    chk_state("ld5", 5, 0, 0);
    en = 1'b1; clr_ovf = 1'b1; cyc();
    clr_ovf = 1'b0;
    chk_state("setwins", 0, 1, 1);

    // reset mid-operation overrides load
    en = 1'b0; limit = 4'd15; load = 1'b1; load_val = 4'd6; cyc();
    check("ld6.Q", 32'(Q), 6);
    en = 1'b1; load_val = 4'd3; reset = 1'b0; cyc();
    chk_state("midrst", 0, 0, 0);
    reset = 1'b1; load = 1'b0;
    cyc(); chk_state("resume1", 1, 0, 0);
    cyc(); chk_state("resume2", 2, 0, 0);

    // zero step, step clamp, down wrap, down out-of-range, saturate hold, zero limit
    step = 4'd0; cyc();
    chk_state("step0", 2, 0, 0);
    limit = 4'd5; step = 4'd9; cyc();
    chk_state("stepclamp", 1, 1, 1);
    dir = 1'b1; limit = 4'd9; step = 4'd3; cyc();
    chk_state("dnwrap", 8, 1, 1);
    limit = 4'd3; cyc();
    chk_state("oor_dn", 3, 1, 1);
    check("oor_dn.at_max", 32'(at_max), 1);
    dir = 1'b0; mode = 1'b1; cyc();
    chk_state("sathold", 3, 1, 1);
    limit = 4'd0; cyc();
    chk_state("lim0", 3, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
